// File: rtl/apb_m_if.sv
// APB requester: single valid/ready command in, IDLE->SETUP->ACCESS on APB, one-cycle response strobe out.
// Latency 3 cycles minimum (accept, SETUP, ACCESS) plus pready wait states; req_ready only in IDLE, no buffering.
// Optional ACCESS timeout under `APB_M_TIMEOUT_EN (abort after TIMEOUT_CYCLES wait cycles, rsp_err=1).
module apb_m_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
    $error("apb_m_if: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    UNUSED = 2'b11
  } state_t;

  state_t                  state, state_nxt;
  logic                    psel_nxt, penable_nxt, pwrite_nxt, rsp_valid_nxt;
  logic [ADDR_WIDTH-1:0]   paddr_nxt;
  logic [DATA_WIDTH-1:0]   pwdata_nxt, rsp_rdata_nxt;

`ifdef APB_M_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt, wait_inc;
  logic             rsp_err_nxt;

  assign wait_inc = wait_cnt + CNT_W'(1);
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready = (state == IDLE);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    psel_nxt      = psel;
    penable_nxt   = penable;
    pwrite_nxt    = pwrite;
    paddr_nxt     = paddr;
    pwdata_nxt    = pwdata;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
`ifdef APB_M_TIMEOUT_EN
    rsp_err_nxt   = rsp_err;
    wait_cnt_nxt  = wait_cnt;
`endif
    case (state)
      IDLE: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        if (req_valid) begin
          pwrite_nxt = req_write;
          paddr_nxt  = req_addr;
          pwdata_nxt = req_wdata;
          psel_nxt   = 1'b1;
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        psel_nxt    = 1'b1;
        penable_nxt = 1'b1;
        state_nxt   = ACCESS;
`ifdef APB_M_TIMEOUT_EN
        wait_cnt_nxt = '0;
`endif
      end
      ACCESS: begin
        psel_nxt    = 1'b1;
        penable_nxt = 1'b1;
        // Completion has priority over a timeout landing on the same edge.
        if (pready) begin
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = pwrite ? '0 : prdata;
          state_nxt     = IDLE;
`ifdef APB_M_TIMEOUT_EN
          rsp_err_nxt   = 1'b0;
`endif
        end
`ifdef APB_M_TIMEOUT_EN
        else if (wait_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b1;
          state_nxt     = IDLE;
        end else begin
          wait_cnt_nxt = wait_inc;
        end
`endif
      end
      default: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      psel      <= psel_nxt;
      penable   <= penable_nxt;
      pwrite    <= pwrite_nxt;
      paddr     <= paddr_nxt;
      pwdata    <= pwdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

`ifdef APB_M_TIMEOUT_EN
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_err  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      rsp_err  <= rsp_err_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end
`endif

endmodule
